// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the prefetch entry type.
package cpu_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched words with their PCs; supports a
// same-cycle push and pop, and a flush that empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  fetch_entry_t   push_data,
  input  logic           pop,
  input  logic           flush,
  output logic [CW-1:0]  count,
  output logic           head_valid,
  output fetch_entry_t   head
);
  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = pop & head_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Pointers return to slot 0; stale contents are unreachable while count is 0.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator for a 1-cycle synchronous ROM: owns the PC, reserves FIFO
// space per issued fetch, captures returning words and handles redirect/halt.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a word moves to decode in any cycle where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low the
  // head (out_valid/out_instr/out_pc) is held unchanged.

  logic [ADDR_W-1:0] pc_q, tag_q;
  logic              inflight_q;
  logic [CW-1:0]     count;
  logic              pop, push, issue;
  logic [CW:0]       used, limit;
  fetch_entry_t      head, push_data;

  assign pop       = out_valid & out_ready;
  assign push      = inflight_q & ~redirect_valid;
  assign push_data = '{instr: imem_instr, pc: tag_q};

  // Space remains when queued plus in-flight words are below DEPTH, with a
  // same-cycle pop freeing one slot.
  assign used  = (CW+1)'(count) + (CW+1)'(inflight_q);
  assign limit = (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign issue = ~redirect_valid & ~halt & (used < limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q       <= pc_q + ADDR_W'(1);
      tag_q      <= pc_q;
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (out_valid),
    .head       (head)
  );

  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for start-up/backpressure, then
// scoreboarded sequences for redirect, PC wrap, halt and mid-stream reset.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               halt = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_target = '0;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  int vectors = 0;
  int miscompares = 0;
  logic sb_en = 1'b0;
  logic [15:0] exp_q[$];

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  // clock / reset and ROM model: 1-cycle sync read, ROM[a] = a ^ A5
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) imem_instr <= '0;
    else       imem_instr <= imem_addr ^ 8'hA5;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] start, input int n);
    logic [7:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 8'(i);
      exp_q.push_back({pc, pc ^ 8'hA5});
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    sb_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // scoreboard: every accepted word is compared against the queue head
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_extra: got pc %h instr %h expected no word", out_pc, out_instr);
      end else begin
        check("sb_word", {out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic       ready;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
    logic [7:0] instr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 8'h02, 1'b1, 8'h00, 8'hA5};
    tbl[3]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[4]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[5]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[6]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[7]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[8]  = '{1'b0, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[9]  = '{1'b1, 8'h03, 1'b1, 8'h01, 8'hA4};
    tbl[10] = '{1'b1, 8'h04, 1'b1, 8'h02, 8'hA7};
    tbl[11] = '{1'b1, 8'h05, 1'b1, 8'h03, 8'hA6};
    tbl[12] = '{1'b1, 8'h06, 1'b1, 8'h04, 8'hA1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_addr",  {8'h00, imem_addr}, 16'h0000);
    check("rst_pc",    {8'h00, out_pc},    16'h0000);
    check("rst_instr", {8'h00, out_instr}, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // start-up latency, throughput and backpressure, one row per cycle
    for (int i = 0; i < 13; i++) begin
      out_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("t%0d_addr", i),  {8'h00, imem_addr}, {8'h00, tbl[i].addr});
      check($sformatf("t%0d_valid", i), {15'd0, out_valid}, {15'd0, tbl[i].valid});
      if (tbl[i].valid) begin
        check($sformatf("t%0d_pc", i),    {8'h00, out_pc},    {8'h00, tbl[i].pc});
        check($sformatf("t%0d_instr", i), {8'h00, out_instr}, {8'h00, tbl[i].instr});
      end
      next_cycle();
    end

    // redirect to 40 with a fetch in flight and decode stalled
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 8'h40;
    next_cycle();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    push_exp(8'h40, 5);
    sb_en = 1'b1;
    @(negedge clk);
    check("redir_valid", {15'd0, out_valid}, 16'h0000);
    check("redir_addr",  {8'h00, imem_addr}, 16'h0040);
    drain("redir40");

    // PC wrap from FD
    redirect_valid = 1'b1;
    redirect_target = 8'hFD;
    next_cycle();
    redirect_valid = 1'b0;
    push_exp(8'hFD, 5);
    sb_en = 1'b1;
    drain("wrap");

    // halt for 5 cycles mid-stream
    redirect_valid = 1'b1;
    redirect_target = 8'h80;
    next_cycle();
    redirect_valid = 1'b0;
    push_exp(8'h80, 12);
    sb_en = 1'b1;
    repeat (3) next_cycle();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("halt%0d_addr", i), {8'h00, imem_addr}, 16'h0083);
      next_cycle();
    end
    halt = 1'b0;
    drain("halt");

    // reset mid-stream with two queued entries
    out_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("prerst_valid", {15'd0, out_valid}, 16'h0001);
    next_cycle();
    reset = 1'b1;
    #1;
    check("midrst_valid", {15'd0, out_valid}, 16'h0000);
    check("midrst_addr",  {8'h00, imem_addr}, {8'h00, RESET_PC});
    check("midrst_pc",    {8'h00, out_pc},    16'h0000);
    next_cycle();
    reset = 1'b0;
    out_ready = 1'b1;
    push_exp(8'h00, 6);
    sb_en = 1'b1;
    drain("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
